cmp_flag_reg: RTL
=================

// Module: cmp_flag_reg
// PURPOSE
//  Downstream stage of comparator16bit in the ALU datapath: registers its ls/eq/gt result,
//  evaluates a selected branch condition and buffers results in a 2-entry queue with
//  valid/ready handshakes. Keeps a saturating count of condition hits for the status block.
// PARAMETERS
//  CNT_W  16  width of hit counter hit_cnt
//  TAG_W  4   width of opaque tag carried alongside each result
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      ls/eq/gt/cond/tag valid this cycle
//  in_ready   out  1      stage can accept; high when queue not full
//  in_ls      in   1      comparator A<B
//  in_eq      in   1      comparator A=B
//  in_gt      in   1      comparator A>B
//  in_cond    in   3      condition select (see BEHAVIOUR)
//  in_tag     in   TAG_W  opaque tag, returned unchanged
//  out_valid  out  1      head entry valid
//  out_ready  in   1      consumer accepts head entry
//  out_ls/out_eq/out_gt out 1 each  registered flags of head entry
//  out_take   out  1      condition result of head entry
//  out_tag    out  TAG_W  tag of head entry
//  clr_cnt    in   1      clear hit_cnt (and err_sticky when enabled)
//  hit_cnt    out  CNT_W  saturating count of accepted entries with take=1
//  err_sticky out  1      illegal flag combination seen (CMP_FLAG_CHECK_EN only)
// BEHAVIOUR
//  - Reset: queue empty, in_ready=1, out_valid=0, out_ls/eq/gt/take=0, out_tag=0, hit_cnt=0, err_sticky=0.
//  - Accept when in_valid&in_ready; pop when out_valid&out_ready. Latency in->out 1 cycle.
//  - Queue FSM EMPTY/ONE/FULL: push only +1; pop only -1; push&pop stays (ONE->ONE, FULL->FULL
//    impossible: in_ready=0 in FULL, so FULL+pop->ONE). Full throughput 1 entry/cycle.
//  - in_ready depends only on registered state (no comb path from out_ready).
//  - Output payload stable while out_valid&~out_ready; entries leave in order.
//  - take computed at accept: 000 LT=ls, 001 LE=ls|eq, 010 EQ=eq, 011 NE=~eq,
//    100 GE=gt|eq, 101 GT=gt, 110 ALWAYS=1, 111 NEVER=0.
//  - hit_cnt += 1 on accept with take=1; saturates at 2^CNT_W-1, never wraps.
//  - clr_cnt with same-cycle hit: hit_cnt=1 (clear then count). clr_cnt does not touch queue.
//  - rst mid-operation: queued entries discarded, no out_valid the following cycle.
// CONFIGURATION
//  CMP_FLAG_CHECK_EN defined: accepted flags checked one-hot; non-one-hot entry still queued
//    with raw flags but take forced 0, not counted, err_sticky set (cleared by rst/clr_cnt;
//    set wins over same-cycle clr_cnt).
//  Undefined: no check, flags used raw, err_sticky tied 0.
// STRUCTURE
//  Shared package cmp_pkg: condition-code constants COND_LT..COND_NEVER, queue state encodings.
//  Sub-module cmp_flag_fifo2: 2-entry valid/ready queue, width 4+TAG_W (ls,eq,gt,take,tag).
//  Top: condition decode, hit counter, error check around cmp_flag_fifo2.
// TESTING
//  1 A=2,B=3 (ls=1), cond=LT, tag=5, out_ready=1 -> next cycle out_valid=1,out_take=1,tag=5,hit_cnt=1.
//  2 out_ready=0, push 3 entries back-to-back -> in_ready=0 after 2nd; 3rd held; release pops in order.
//  3 eq=1 each cycle, cond=NE x4 then EQ x4 -> takes 0,0,0,0,1,1,1,1; hit_cnt=4.
//  4 CNT_W=4, 20 hits -> hit_cnt=15 and holds; clr_cnt with hit same cycle -> hit_cnt=1.
//  5 CMP_FLAG_CHECK_EN, ls=1,gt=1, cond=ALWAYS -> out_take=0, hit_cnt unchanged, err_sticky=1.
//  6 queue FULL, assert rst 1 cycle -> out_valid=0, in_ready=1, hit_cnt=0 next cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator flag stage: condition-code constants,
// queue state encodings and the branch-condition evaluator.
package cmp_pkg;

    localparam logic [2:0] COND_LT     = 3'b000;
    localparam logic [2:0] COND_LE     = 3'b001;
    localparam logic [2:0] COND_EQ     = 3'b010;
    localparam logic [2:0] COND_NE     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_GT     = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'b00,
        Q_ONE   = 2'b01,
        Q_FULL  = 2'b10
    } q_state_t;

    // Evaluate one condition code against raw comparator flags.
    function automatic logic cond_eval(input logic [2:0] cond,
                                       input logic       ls,
                                       input logic       eq,
                                       input logic       gt);
        logic r;
        case (cond)
            COND_LT:     r = ls;
            COND_LE:     r = ls | eq;
            COND_EQ:     r = eq;
            COND_NE:     r = ~eq;
            COND_GE:     r = gt | eq;
            COND_GT:     r = gt;
            COND_ALWAYS: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_flag_fifo2.sv
// Two-entry valid/ready queue with a registered head. in_ready and out_valid are
// decoded from the registered state only, so there is no path from out_ready to
// in_ready. Full throughput: push and pop may happen in the same cycle.
module cmp_flag_fifo2
    import cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    q_state_t     state_reg;
    logic [W-1:0] head_reg;
    logic [W-1:0] tail_reg;
    logic         push;
    logic         pop;

    assign in_ready  = (state_reg != Q_FULL);
    assign out_valid = (state_reg != Q_EMPTY);
    assign out_data  = head_reg;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Queue occupancy FSM; head_reg always holds the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= Q_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            case (state_reg)
                Q_EMPTY: begin
                    if (push) begin
                        head_reg  <= in_data;
                        state_reg <= Q_ONE;
                    end
                end
                Q_ONE: begin
                    if (push && pop) begin
                        head_reg <= in_data;
                    end else if (push) begin
                        tail_reg  <= in_data;
                        state_reg <= Q_FULL;
                    end else if (pop) begin
                        state_reg <= Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        head_reg  <= tail_reg;
                        state_reg <= Q_ONE;
                    end
                end
                default: state_reg <= Q_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/cmp_flag_reg.sv
// Comparator flag stage: evaluates the selected branch condition on accept,
// queues {ls,eq,gt,take,tag} in a 2-entry queue and keeps a saturating hit count.
// Optional feature macro: CMP_FLAG_CHECK_EN (one-hot flag check with err_sticky).
module cmp_flag_reg
    import cmp_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ls,
    input  logic             in_eq,
    input  logic             in_gt,
    input  logic [2:0]       in_cond,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ls,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_take,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             err_sticky
);

    localparam int             W       = 4 + TAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]       cond_vec;
    logic             take_raw;
    logic             take;
    logic             accept;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt_reg;
    logic [W-1:0]     q_in;
    logic [W-1:0]     q_out;

    // Every condition evaluated in parallel; in_cond picks one.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cond
            assign cond_vec[gi] = cond_eval(3'(gi), in_ls, in_eq, in_gt);
        end
    endgenerate

    assign take_raw = cond_vec[in_cond];
    assign accept   = in_valid & in_ready;
    assign hit      = accept & take;

`ifdef CMP_FLAG_CHECK_EN
    logic flags_onehot;
    logic err_sticky_reg;

    assign flags_onehot = ( in_ls & ~in_eq & ~in_gt) |
                          (~in_ls &  in_eq & ~in_gt) |
                          (~in_ls & ~in_eq &  in_gt);
    assign take       = take_raw & flags_onehot;
    assign err_sticky = err_sticky_reg;

    // Sticky illegal-flag indicator; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_reg <= 1'b0;
        end else if (accept && !flags_onehot) begin
            err_sticky_reg <= 1'b1;
        end else if (clr_cnt) begin
            err_sticky_reg <= 1'b0;
        end
    end
`else
    assign take       = take_raw;
    assign err_sticky = 1'b0;
`endif

    // Saturating hit counter; clear happens before the same-cycle count.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg <= '0;
        end else if (clr_cnt) begin
            hit_cnt_reg <= hit ? CNT_W'(1) : '0;
        end else if (hit && hit_cnt_reg != CNT_MAX) begin
            hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
        end
    end

    assign hit_cnt = hit_cnt_reg;
    assign q_in    = {in_ls, in_eq, in_gt, take, in_tag};

    cmp_flag_fifo2 #(
        .W (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (q_out)
    );

    assign out_ls   = q_out[W-1];
    assign out_eq   = q_out[W-2];
    assign out_gt   = q_out[W-3];
    assign out_take = q_out[W-4];
    assign out_tag  = q_out[TAG_W-1:0];

endmodule
